// File: rtl/gshare_pht_predictor.sv
// rtl/gshare_pht_predictor.sv - gshare branch predictor: GHR-xor-PC indexed PHT of saturating counters
// GSHARE_BYPASS_EN: forward a same-cycle same-index update into the prediction read.
module gshare_pht_predictor #(
  parameter int HIST_W = 4,
  parameter int CTR_W  = 2,
  parameter int PC_LSB = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_valid,
  input  logic [31:0]       pred_pc,
  output logic              pred_out_valid,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_index,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [HIST_W-1:0] upd_index,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic [HIST_W-1:0] upd_ghr
);

  localparam int DEPTH = 1 << HIST_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};

  logic [HIST_W-1:0] ghr;
  logic [CTR_W-1:0]  pht [DEPTH];
  logic [HIST_W-1:0] rd_index;
  logic [CTR_W-1:0]  rd_ctr;
  logic [CTR_W-1:0]  upd_ctr;
  logic [CTR_W-1:0]  upd_next;
  logic              taken;
  logic              unused_bits;

  assign unused_bits = ^{pred_pc, upd_ghr[HIST_W-1]};

  always_comb begin
    rd_index = pred_pc[PC_LSB +: HIST_W] ^ ghr;
    upd_ctr  = pht[upd_index];
    upd_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_next = upd_ctr + CTR_ONE;
    end else begin
      if (upd_ctr != '0) upd_next = upd_ctr - CTR_ONE;
    end
`ifdef GSHARE_BYPASS_EN
    rd_ctr = (upd_valid && (upd_index == rd_index)) ? upd_next : pht[rd_index];
`else
    rd_ctr = pht[rd_index];
`endif
    taken = rd_ctr[CTR_W-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CTR_INIT;
    end else if (upd_valid) begin
      pht[upd_index] <= upd_next;
    end
  end

  // Recovery from a mispredict wins over the speculative shift of a same-cycle request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_valid && upd_mispredict) begin
      ghr <= {upd_ghr[HIST_W-2:0], upd_taken};
    end else if (pred_valid) begin
      ghr <= {ghr[HIST_W-2:0], taken};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_index     <= '0;
      pred_ghr       <= '0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) begin
        pred_taken <= taken;
        pred_index <= rd_index;
        pred_ghr   <= ghr;
      end
    end
  end

endmodule

// File: tb/tb_gshare_pht_predictor.sv
// tb/tb_gshare_pht_predictor.sv - scoreboard bench for gshare_pht_predictor against an array model
// GSHARE_BYPASS_EN selects the forwarding expectation, matching the RTL build.
module tb_gshare_pht_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_out_valid;
  logic        pred_taken;
  logic [3:0]  pred_index;
  logic [3:0]  pred_ghr;
  logic        upd_valid = 1'b0;
  logic [3:0]  upd_index = '0;
  logic        upd_taken = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic [3:0]  upd_ghr = '0;

  gshare_pht_predictor dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
    .pred_index(pred_index), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr)
  );

  always #5 clk = ~clk;

  typedef struct { bit t; int idx; int g; } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int m_pht [16];
  int m_ghr;
  bit last_t;
  int last_idx, last_g;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pht[i] = 1;
    m_ghr = 0;
  endtask

  // Applies inputs for one cycle, advances the model, queues the expected prediction.
  task automatic drive(bit pv, int unsigned pc, bit uv, int ui, bit ut, bit um, int ug);
    int idx, c, nc;
    bit t;
    pred_valid = pv; pred_pc = pc; upd_valid = uv; upd_index = ui[3:0];
    upd_taken = ut; upd_mispredict = um; upd_ghr = ug[3:0];
    idx = (int'(pc / 4) % 16) ^ m_ghr;
    c = m_pht[idx];
    nc = ut ? ((m_pht[ui] == 3) ? 3 : m_pht[ui] + 1) : ((m_pht[ui] == 0) ? 0 : m_pht[ui] - 1);
`ifdef GSHARE_BYPASS_EN
    if (uv && ui == idx) c = nc;
`endif
    t = (c >= 2);
    if (pv) q.push_back('{t: t, idx: idx, g: m_ghr});
    if (uv) m_pht[ui] = nc;
    if (uv && um) m_ghr = (ug * 2 + int'(ut)) % 16;
    else if (pv) m_ghr = (m_ghr * 2 + int'(t)) % 16;
    @(negedge clk);
  endtask

  function automatic int unsigned pc_for(int idx);
    return ((idx ^ m_ghr) * 4);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (pred_out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("pred_taken", int'(pred_taken), int'(e.t));
          check("pred_index", int'(pred_index), e.idx);
          check("pred_ghr", int'(pred_ghr), e.g);
        end
        last_t = pred_taken; last_idx = int'(pred_index); last_g = int'(pred_ghr);
      end else begin
        check("hold_taken", int'(pred_taken), int'(last_t));
        check("hold_index", int'(pred_index), last_idx);
        check("hold_ghr", int'(pred_ghr), last_g);
      end
    end
  end

  initial begin : stim
    int unsigned pc;
    int idx;
    model_reset();
    last_t = 0; last_idx = 0; last_g = 0;
    #1;
    check("rst_valid", int'(pred_out_valid), 0);
    check("rst_taken", int'(pred_taken), 0);
    check("rst_index", int'(pred_index), 0);
    check("rst_ghr", int'(pred_ghr), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // First request from reset: index 4, not taken, history stays zero
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Train index 4 up to saturation, then down to saturation
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 4, 1, 0, 0);
    drive(1, pc_for(4), 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 4, 0, 0, 0);
    drive(1, pc_for(4), 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Recovery overrides a same-cycle speculative shift
    drive(1, 32'h24, 1, 9, 1, 1, 5);
    drive(1, 32'h0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Same-cycle predict and taken update to a weakly not-taken index 4
    drive(0, 0, 1, 4, 1, 0, 0);
    m_ghr = m_ghr;
    drive(1, pc_for(4), 1, 4, 1, 0, 0);
    drive(1, pc_for(4), 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      pc = $urandom;
      idx = (int'(pc / 4) % 16) ^ m_ghr;
      drive(($urandom % 4) != 0, pc, $urandom % 2,
            ($urandom % 3 == 0) ? idx : int'($urandom % 16),
            $urandom % 2, ($urandom % 5) == 0, int'($urandom % 16));
    end

    // Reset pulse between a request and the next edge drops it and restores fresh state
    pred_valid = 1'b1; pred_pc = $urandom; upd_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", int'(pred_out_valid), 0);
    q.delete();
    model_reset();
    last_t = 0; last_idx = 0; last_g = 0;
    pred_valid = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) drive(1, 32'(i * 4), 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gshare_pht_predictor.md
GSHARE_PHT_PREDICTOR -- requirements
Module: gshare_pht_predictor

Interface
REQ-001 Parameter HIST_W, default 4: GHR width; PHT depth = 2^HIST_W entries.
REQ-002 Parameter CTR_W, default 2: saturating counter width per PHT entry; legal range 2..4.
REQ-003 Parameter PC_LSB, default 2: lowest PC bit used in indexing; index PC slice = pred_pc[PC_LSB +: HIST_W].
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 pred_valid  in  1  prediction request this cycle.
REQ-007 pred_pc  in  32  branch address of the request.
REQ-008 pred_out_valid  out  1  registered; prediction result valid.
REQ-009 pred_taken  out  1  predicted direction, equal to counter MSB.
REQ-010 pred_index  out  HIST_W  PHT index used; caller returns it on update.
REQ-011 pred_ghr  out  HIST_W  GHR snapshot used for the index (pre-shift); caller returns it for recovery.
REQ-012 upd_valid  in  1  branch resolution this cycle.
REQ-013 upd_index  in  HIST_W  PHT entry to train.
REQ-014 upd_taken  in  1  actual direction.
REQ-015 upd_mispredict  in  1  resolved direction differed from prediction.
REQ-016 upd_ghr  in  HIST_W  GHR snapshot returned from the prediction.

Function
REQ-017 Index = pred_pc[PC_LSB +: HIST_W] XOR ghr, using ghr value before this cycle's update.
REQ-018 Latency: pred_valid in cycle N -> pred_out_valid=1 with pred_taken/pred_index/pred_ghr in cycle N+1; pred_out_valid=0 in cycles following no request; outputs hold last values while pred_out_valid=0.
REQ-019 Speculative history: on pred_valid, ghr <= {ghr[HIST_W-2:0], predicted direction}.
REQ-020 Recovery: on upd_valid & upd_mispredict, ghr <= {upd_ghr[HIST_W-2:0], upd_taken}; recovery overrides a same-cycle speculative shift.
REQ-021 Training: on upd_valid, PHT[upd_index] increments if upd_taken, else decrements; saturates at 0 and 2^CTR_W-1 (no wrap).
REQ-022 upd_valid with upd_mispredict=0 leaves ghr unchanged by the update path.
REQ-023 Same-cycle predict and update to different indices are independent; both complete.
REQ-024 Same-cycle predict and update to the same index: behaviour per REQ-028/REQ-029.
REQ-025 No back-pressure: one prediction and one update accepted every cycle.

Reset
REQ-026 While reset=1, asynchronously: ghr=0; every PHT entry=2^(CTR_W-1)-1 (weakly not-taken, 01 for CTR_W=2); pred_out_valid=0, pred_taken=0, pred_index=0, pred_ghr=0.
REQ-027 Reset asserted mid-operation discards any in-flight prediction; the first request after deassertion behaves as if issued from a fresh reset.

Configuration
REQ-028 Macro GSHARE_BYPASS_EN defined: same-index same-cycle update is forwarded; pred_taken reflects the post-update counter.
REQ-029 GSHARE_BYPASS_EN undefined: read-before-write; pred_taken reflects the pre-update counter; the update still commits.

Verification
REQ-030 Reset, pred_valid=1, pred_pc=0x0000_0010 -> next cycle pred_out_valid=1, pred_index=4'h4, pred_ghr=0, pred_taken=0; ghr stays 4'h0.
REQ-031 Three upd_valid taken at upd_index=4 from reset -> counter 01->10->11->11; prediction at index 4 then gives pred_taken=1.
REQ-032 Four upd_valid not-taken at index 4 from 11 -> 10->01->00->00; pred_taken=0.
REQ-033 upd_mispredict=1, upd_ghr=4'b0101, upd_taken=1, with simultaneous pred_valid -> next-cycle ghr=4'b1011; speculative shift discarded.
REQ-034 Counter at 01, same-cycle pred and taken update to index 4 -> pred_taken=0 without GSHARE_BYPASS_EN, 1 with it; counter becomes 10 in both.
REQ-035 reset pulsed between pred_valid and the next edge -> pred_out_valid stays 0, all PHT entries read 01, ghr=0.
